mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports mem_read_flag, mem_write_flag, mem_sign_ext_flag  input  1 each  access controls from the decode stage.
REQ-004 SHALL have ports: mem_sel  input  4  access size, 0001 byte, 0011 half, 1111 word; mem_write_data  input  32  store data, right-justified.
REQ-005 SHALL have ports: mem_addr  input  32  effective byte address; stall_request  output  1  holds the pipeline.
REQ-006 SHALL have ports: load_data  output  32  extended load result; load_valid  output  1  load_data valid this cycle.
REQ-007 SHALL have bus ports: bus_en  output  1; bus_wen  output  4; bus_addr  output  32; bus_wdata  output  32; bus_rdata  input  32; bus_ready  input  1.
REQ-008 SHALL have ports: addr_error  output  1  misaligned-access pulse; bad_vaddr  output  32  faulting address.

Function
REQ-009 SHALL implement FSM IDLE, REQ, DONE.
REQ-010 In IDLE with read or write flag set, SHALL register addr, sel, data, sign flag, direction, and go to REQ.
REQ-011 In IDLE, stall_request SHALL equal (mem_read_flag | mem_write_flag) combinationally; in REQ it SHALL be 1; in DONE it SHALL be 0.
REQ-012 In REQ, bus_en SHALL be 1 and bus_addr SHALL be {addr[31:2], 2'b00}; all bus outputs SHALL be 0 in IDLE and DONE.
REQ-013 Writes: bus_wen SHALL be sel shifted left by addr[1:0]; bus_wdata SHALL be byte replicated x4, half replicated x2, or word; reads drive bus_wen 0000.
REQ-014 REQ SHALL remain until bus_ready is 1, with all bus outputs held stable; bus_ready in the first REQ cycle (zero wait) SHALL be accepted.
REQ-015 On bus_ready in REQ, SHALL capture bus_rdata (reads) and go to DONE.
REQ-016 Reads: load_data SHALL be the lane at byte offset addr[1:0] (little-endian), sign-extended if sign flag, else zero-extended; word passes unchanged.
REQ-017 load_valid SHALL be 1 only in DONE after a read; load_data SHALL hold its value until the next read completes.
REQ-018 DONE SHALL last exactly one cycle, return to IDLE, and not sample inputs; minimum access = 3 cycles, 2 stalled.
REQ-019 Both flags set SHALL be treated as a write; any mem_sel value other than 0001/0011 SHALL be treated as word.
REQ-020 bus_ready outside REQ SHALL be ignored.

Reset
REQ-021 Reset asserted SHALL force IDLE immediately, aborting any access mid-REQ; bus_en, bus_wen, stall_request, load_valid, addr_error SHALL drop asynchronously.
REQ-022 Reset values: all outputs 0; registered load_data 32'h0, bad_vaddr 32'h0.

Configuration
REQ-023 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL NOT enter REQ, SHALL pulse addr_error for one cycle (registered, cycle after request), load bad_vaddr with mem_addr, and deassert stall_request.
REQ-024 Macro undefined: no check; word ignores addr[1:0], half ignores addr[0]; addr_error and bad_vaddr tied 0.

Structure
REQ-025 FSM state encodings, mem_sel size constants, and bus width defines SHALL live in the shared define headers alongside the existing bus/opcode defines.
REQ-026 Byte-lane write alignment and load extraction/extension SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-027 Word load, addr 0x0000_1004, bus_rdata 0xDEADBEEF, ready in first REQ cycle -> bus_addr 0x0000_1004, load_data 0xDEADBEEF, load_valid in cycle 3, stall 2 cycles.
REQ-028 LB sign, addr 0x...03, bus_rdata 0x80FF_FFFF -> load_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-029 SH data 0x0000_1234, addr 0x...02, 3 wait cycles -> bus_wen 1100, bus_wdata 0x1234_1234 held stable 4 cycles, stall 5 cycles.
REQ-030 rst low during REQ -> bus_en 0 same cycle, IDLE after release, no load_valid.
REQ-031 With MEM_ALIGN_CHECK_EN, LW at 0x0000_1002 -> no bus_en, addr_error one cycle, bad_vaddr 0x0000_1002; without macro -> bus_addr 0x0000_1000.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store access unit: FSM states, mem_sel size codes, bus width.
package mem_access_unit_pkg;

    localparam int BUS_W = 32;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Any mem_sel encoding other than byte/half is treated as a word access.
    function automatic acc_size_t decode_size(input logic [3:0] sel);
        if (sel == SEL_BYTE)      return SZ_BYTE;
        else if (sel == SEL_HALF) return SZ_HALF;
        else                      return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: write enables/replicated store data, and load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wen         = 4'b1111;
        wdata_lanes = wdata;
        load_data   = rdata;
        case (acc_size_t'(size))
            SZ_BYTE: begin
                wen         = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                // addr_lo[0] is ignored: halves always sit on a 16-bit lane.
                wen         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: IDLE->REQ->DONE bus handshake, stalls the pipeline while the access is outstanding.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a one-cycle addr_error pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] mem_addr,
    output logic        stall_request,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_en,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        addr_error,
    output logic [31:0] bad_vaddr
);

    state_t      state, state_nxt;
    acc_size_t   size_in;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        sign_q, write_q;
    logic        req, misalign, accept;
    logic [3:0]  lane_wen;
    logic [31:0] lane_wdata, lane_load;

    assign req     = mem_read_flag | mem_write_flag;
    assign size_in = decode_size(mem_sel);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = is_misaligned(size_in, mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && req && !misalign;

    mem_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .sign_ext    (sign_q),
        .wdata       (wdata_q),
        .rdata       (bus_rdata),
        .wen         (lane_wen),
        .wdata_lanes (lane_wdata),
        .load_data   (lane_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        stall_request = 1'b0;
        bus_en        = 1'b0;
        bus_wen       = 4'b0000;
        bus_addr      = '0;
        bus_wdata     = '0;
        load_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by rst so the stall drops the moment reset asserts.
                stall_request = rst & req & !misalign;
                if (accept) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                stall_request = 1'b1;
                bus_en        = 1'b1;
                bus_addr      = {addr_q[31:2], 2'b00};
                bus_wen       = write_q ? lane_wen : 4'b0000;
                bus_wdata     = write_q ? lane_wdata : 32'h0;
                if (bus_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                load_valid = !write_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_WORD;
            sign_q    <= 1'b0;
            write_q   <= 1'b0;
            load_data <= '0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_write_data;
                size_q  <= size_in;
                sign_q  <= mem_sign_ext_flag;
                write_q <= mem_write_flag;
            end
            if (state == ST_REQ && bus_ready && !write_q)
                load_data <= lane_load;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_error <= 1'b0;
            bad_vaddr  <= '0;
        end else begin
            addr_error <= (state == ST_IDLE) && req && misalign;
            if ((state == ST_IDLE) && req && misalign)
                bad_vaddr <= mem_addr;
        end
    end
`else
    assign addr_error = 1'b0;
    assign bad_vaddr  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized load/store accesses against a byte-arithmetic reference model, plus directed corner cases and reset abort.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data, mem_addr;
    logic        stall_request;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready;
    logic        addr_error;
    logic [31:0] bad_vaddr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_load = 32'h0;
    logic [3:0]  sel_tab [5] = '{4'b0001, 4'b0011, 4'b1111, 4'b0101, 4'b0000};

    mem_access_unit dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .mem_sel           (mem_sel),
        .mem_write_data    (mem_write_data),
        .mem_addr          (mem_addr),
        .stall_request     (stall_request),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .bus_en            (bus_en),
        .bus_wen           (bus_wen),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ready         (bus_ready),
        .addr_error        (addr_error),
        .bad_vaddr         (bad_vaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes_of(input logic [3:0] sel);
        if (sel == 4'b0001) return 1;
        if (sel == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input int nb, input logic [31:0] a);
        if (nb == 1) return int'(a % 4);
        if (nb == 2) return int'((a % 4) / 2 * 2);
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input int nb, input int off, input logic sgn,
                                               input logic [31:0] rd);
        logic [31:0] v, mask;
        v = rd >> (off * 8);
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v    = v & mask;
            if (sgn && v[8 * nb - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic drive_idle();
        mem_read_flag     = 1'b0;
        mem_write_flag    = 1'b0;
        mem_sign_ext_flag = 1'b0;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic sgn, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits, input logic done_noise);
        int          nb, off;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
        nb        = nbytes_of(sel);
        off       = lane_off(nb, addr);
        exp_wen   = 4'(((1 << nb) - 1) << off);
        exp_wdata = (nb == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                    (nb == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;

        @(negedge clk);
        mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sgn;
        mem_sel = sel; mem_addr = addr; mem_write_data = wdata;
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        #1;
        check("idle_stall", 32'(stall_request), 32'd1);
        check("idle_bus_en", 32'(bus_en), 32'd0);

        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            drive_idle();
            mem_addr = $urandom; mem_write_data = $urandom;
            mem_sel = sel_tab[$urandom_range(0, 4)];
            bus_ready = (k == waits);
            bus_rdata = (k == waits) ? rdata : $urandom;
            #1;
            check("req_stall", 32'(stall_request), 32'd1);
            check("req_bus_en", 32'(bus_en), 32'd1);
            check("req_bus_addr", bus_addr, addr & ~32'h3);
            check("req_bus_wen", 32'(bus_wen), wr ? 32'(exp_wen) : 32'd0);
            if (wr) check("req_bus_wdata", bus_wdata, exp_wdata);
            check("req_load_valid", 32'(load_valid), 32'd0);
            check("req_load_hold", load_data, last_load);
        end

        @(negedge clk);
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        if (done_noise) begin
            mem_read_flag = 1'b1; mem_write_flag = 1'($urandom); mem_addr = $urandom;
        end
        #1;
        if (!wr) last_load = model_load(nb, off, sgn, rdata);
        check("done_stall", 32'(stall_request), 32'd0);
        check("done_bus_en", 32'(bus_en), 32'd0);
        check("done_bus_wen", 32'(bus_wen), 32'd0);
        check("done_load_valid", 32'(load_valid), wr ? 32'd0 : 32'd1);
        check("done_load_data", load_data, last_load);

        @(negedge clk);
        drive_idle();
        bus_ready = 1'b1;
        #1;
        check("post_stall", 32'(stall_request), 32'd0);
        check("post_bus_en", 32'(bus_en), 32'd0);
        check("post_load_valid", 32'(load_valid), 32'd0);
        check("post_load_data", load_data, last_load);
    endtask

    initial begin
        rst = 1'b0;
        mem_read_flag = 1'b1; mem_write_flag = 1'b0; mem_sign_ext_flag = 1'b0;
        mem_sel = 4'b1111; mem_addr = 32'h0; mem_write_data = 32'h0;
        bus_rdata = 32'h0; bus_ready = 1'b1;
        #2;
        check("rst_stall", 32'(stall_request), 32'd0);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_wen", 32'(bus_wen), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_addr_error", 32'(addr_error), 32'd0);
        check("rst_bad_vaddr", bad_vaddr, 32'd0);
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_access(1, 0, 0, 4'b1111, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("lw_directed", load_data, 32'hDEAD_BEEF);
        do_access(1, 0, 1, 4'b0001, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1, 0);
        check("lb_directed", load_data, 32'hFFFF_FF80);
        do_access(1, 0, 0, 4'b0001, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 0, 0);
        check("lbu_directed", load_data, 32'h0000_0080);
        do_access(0, 1, 0, 4'b0011, 32'h0000_3002, 32'h0000_1234, 32'h0, 3, 1);
        check("sh_keeps_load", load_data, 32'h0000_0080);
        do_access(1, 1, 1, 4'b0001, 32'h0000_4001, 32'h0000_00A5, 32'h0, 2, 0);

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        mem_read_flag = 1'b1; mem_sel = 4'b1111; mem_addr = 32'h0000_1002;
        #1;
        check("mis_stall", 32'(stall_request), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("mis_addr_error", 32'(addr_error), 32'd1);
        check("mis_bad_vaddr", bad_vaddr, 32'h0000_1002);
        check("mis_bus_en", 32'(bus_en), 32'd0);
        @(negedge clk);
        #1;
        check("mis_pulse_end", 32'(addr_error), 32'd0);
`else
        do_access(1, 0, 0, 4'b1111, 32'h0000_1002, 32'h0, 32'h1357_9BDF, 0, 0);
        check("lw_unaligned_data", load_data, 32'h1357_9BDF);
        check("no_addr_error", 32'(addr_error), 32'd0);
        check("no_bad_vaddr", bad_vaddr, 32'd0);
`endif

        // Reset asserted in the middle of an outstanding access.
        @(negedge clk);
        mem_read_flag = 1'b1; mem_sel = 4'b1111; mem_addr = 32'h0000_5000; bus_ready = 1'b0;
        @(negedge clk);
        drive_idle();
        #1;
        check("abort_pre_bus_en", 32'(bus_en), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_bus_en", 32'(bus_en), 32'd0);
        check("abort_stall", 32'(stall_request), 32'd0);
        check("abort_load_valid", 32'(load_valid), 32'd0);
        check("abort_load_data", load_data, 32'd0);
        last_load = 32'h0;
        @(negedge clk);
        rst = 1'b1; bus_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("abort_idle_bus_en", 32'(bus_en), 32'd0);
            check("abort_idle_load_valid", 32'(load_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  dir;
            logic [3:0]  sel;
            logic [31:0] a;
            dir = 2'($urandom_range(1, 3));
            sel = sel_tab[$urandom_range(0, 4)];
            a   = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            a = a & ~32'(nbytes_of(sel) - 1);
`endif
            do_access(dir[0], dir[1], 1'($urandom), sel, a, $urandom, $urandom,
                      $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
